// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter
//   Two-requester round-robin arbiter in front of a single native-interface
//   memory port (system memory path ahead of the AXI DDR bridge).
//   Requester 0 is the instruction side, requester 1 the data side.
//   Only one transaction is outstanding at a time. All memory-side request
//   signals and requester ready/rdata are registered.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0_* / m1_*              native requester ports (valid/addr/wdata/wstrb in,
//                            rdata/ready out); wstrb == 0 means read
//   mem_valid/addr/wdata/wstrb  registered memory request
//   mem_rdata, mem_ready     memory response; mem_ready is a one-cycle pulse
//   grant                    index of the last or current granted requester
//   busy                     high while a transaction is in flight or responding
module iob_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_valid,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_ready,

  input  logic                  m1_valid,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_ready,

  output logic                  mem_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,

  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic              any_valid;
  logic              sel;

  assign any_valid = m0_valid | m1_valid;

  // With both requesting, the one that did not win last time is chosen;
  // otherwise the lone requester wins. grant resets to 1 so m0 wins the
  // first tie.
  assign sel = (m0_valid & m1_valid) ? ~grant : m1_valid;

  // Both requesters see the same captured read data; it is only meaningful
  // while the matching ready is high.
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

  // State register and registered request/response path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rdata_q   <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
    end else begin
      state    <= state_nxt;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant     <= sel;
            mem_valid <= 1'b1;
            mem_addr  <= sel ? m1_addr  : m0_addr;
            mem_wdata <= sel ? m1_wdata : m0_wdata;
            mem_wstrb <= sel ? m1_wstrb : m0_wstrb;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            rdata_q   <= mem_rdata;
            mem_valid <= 1'b0;
            m0_ready  <= ~grant;
            m1_ready  <= grant;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic; requester valids are ignored in RESP and
  // mem_ready is ignored outside BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Testbench for iob_mem_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level reference model and a
// reference memory scoreboard.
module tb_iob_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SW     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_valid = 1'b0;
  logic [ADDR_W-1:0] m0_addr  = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic [SW-1:0]     m0_wstrb = '0;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ready;
  logic              m1_valid = 1'b0;
  logic [ADDR_W-1:0] m1_addr  = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic [SW-1:0]     m1_wstrb = '0;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SW-1:0]     mem_wstrb;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              grant;
  logic              busy;

  always #5 clk = ~clk;

  iob_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wstrb;
  } txn_t;

  int total = 0;
  int bad   = 0;

  // requester drivers
  txn_t plan0[$];
  txn_t plan1[$];
  txn_t cur0 = '0;
  txn_t cur1 = '0;
  bit   act0 = 1'b0;
  bit   act1 = 1'b0;
  int   p_req0 = 100;
  int   p_req1 = 100;

  // memory slave and reference memory
  logic [DATA_W-1:0] smem [64];
  logic [DATA_W-1:0] rmem [64];
  bit   mem_pend = 1'b0;
  int   mem_cnt  = 0;
  int   fixed_wait = -1;
  int   p_spur = 0;

  // reference model of the arbiter at transaction level
  bit                in_flight;
  bit                resp_due;
  logic              last;
  logic              exp_m0_ready;
  logic              exp_m1_ready;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  logic [SW-1:0]     exp_wstrb;
  logic [DATA_W-1:0] exp_rdata;

  // observed grants (from the DUT) for ordering/fairness checks
  int   cyc = 0;
  logic prev_mv = 1'b0;
  int   g_who[$];
  int   g_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] nw,
                                              input logic [SW-1:0] st);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.addr  = ADDR_W'($urandom_range(0, 63) << 2);
    t.wdata = $urandom;
    t.wstrb = ($urandom_range(0, 2) == 0) ? SW'($urandom) : '0;
    return t;
  endfunction

  task automatic add(input int who, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
    txn_t t;
    t.addr = a; t.wdata = d; t.wstrb = s;
    if (who == 0) plan0.push_back(t);
    else          plan1.push_back(t);
  endtask

  task automatic model_reset();
    in_flight    = 1'b0;
    resp_due     = 1'b0;
    last         = 1'b1;
    exp_m0_ready = 1'b0;
    exp_m1_ready = 1'b0;
    exp_addr     = '0;
    exp_wdata    = '0;
    exp_wstrb    = '0;
    exp_rdata    = '0;
    prev_mv      = 1'b0;
  endtask

  // One clock edge of the reference: a transaction is either waiting on the
  // memory, delivering its response, or a new request gets picked.
  task automatic model_edge();
    logic owner;
    exp_m0_ready = 1'b0;
    exp_m1_ready = 1'b0;
    if (in_flight) begin
      if (mem_ready) begin
        in_flight = 1'b0;
        resp_due  = 1'b1;
        exp_rdata = mem_rdata;
        if (last == 1'b0) exp_m0_ready = 1'b1;
        else              exp_m1_ready = 1'b1;
      end
    end else if (resp_due) begin
      resp_due = 1'b0;
    end else if (m0_valid || m1_valid) begin
      owner     = (m0_valid && m1_valid) ? ~last : m1_valid;
      last      = owner;
      in_flight = 1'b1;
      exp_addr  = owner ? m1_addr  : m0_addr;
      exp_wdata = owner ? m1_wdata : m0_wdata;
      exp_wstrb = owner ? m1_wstrb : m0_wstrb;
    end
  endtask

  task automatic check_all();
    chk("mem_valid", 64'(mem_valid), 64'(in_flight));
    chk("busy",      64'(busy),      64'(in_flight | resp_due));
    chk("grant",     64'(grant),     64'(last));
    chk("m0_ready",  64'(m0_ready),  64'(exp_m0_ready));
    chk("m1_ready",  64'(m1_ready),  64'(exp_m1_ready));
    chk("mem_addr",  64'(mem_addr),  64'(exp_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_wstrb));
    chk("m0_rdata_reg", 64'(m0_rdata), 64'(exp_rdata));
    chk("m1_rdata_reg", 64'(m1_rdata), 64'(exp_rdata));
  endtask

  task automatic sb(input int who, input txn_t t, input logic [DATA_W-1:0] rd);
    if (t.wstrb == '0)
      chk((who == 0) ? "m0_read_data" : "m1_read_data", 64'(rd), 64'(rmem[t.addr[7:2]]));
    else
      rmem[t.addr[7:2]] = merge(rmem[t.addr[7:2]], t.wdata, t.wstrb);
  endtask

  task automatic drive_req();
    if (m0_ready) begin sb(0, cur0, m0_rdata); act0 = 1'b0; end
    if (m1_ready) begin sb(1, cur1, m1_rdata); act1 = 1'b0; end
    if (!act0 && plan0.size() > 0 && int'($urandom_range(0, 99)) < p_req0) begin
      cur0 = plan0.pop_front(); act0 = 1'b1;
    end
    if (!act1 && plan1.size() > 0 && int'($urandom_range(0, 99)) < p_req1) begin
      cur1 = plan1.pop_front(); act1 = 1'b1;
    end
    m0_valid = act0; m0_addr = cur0.addr; m0_wdata = cur0.wdata; m0_wstrb = cur0.wstrb;
    m1_valid = act1; m1_addr = cur1.addr; m1_wdata = cur1.wdata; m1_wstrb = cur1.wstrb;
  endtask

  task automatic drive_mem();
    mem_ready = 1'b0;
    if (mem_valid) begin
      if (!mem_pend) begin
        mem_pend = 1'b1;
        mem_cnt  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (mem_cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = smem[mem_addr[7:2]];
        if (mem_wstrb != '0)
          smem[mem_addr[7:2]] = merge(smem[mem_addr[7:2]], mem_wdata, mem_wstrb);
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else begin
      mem_pend = 1'b0;
      if (int'($urandom_range(0, 99)) < p_spur) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) model_edge();
    #1;
    check_all();
    if (mem_valid && !prev_mv) begin
      g_who.push_back(int'(grant));
      g_cyc.push_back(cyc);
    end
    prev_mv = mem_valid;
    drive_req();
    drive_mem();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((plan0.size() > 0 || plan1.size() > 0 || act0 || act1 || in_flight || resp_due)
           && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= budget), 64'(0));
  endtask

  // Raise reset between clock edges and check its effect before any edge.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    plan0.delete(); plan1.delete();
    act0 = 1'b0; act1 = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    mem_pend = 1'b0; mem_ready = 1'b0;
    check_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int zeros;
    for (int i = 0; i < 64; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end
    smem[4] = 32'hDEADBEEF;
    rmem[4] = 32'hDEADBEEF;
    model_reset();

    // reset values
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // 1: m0 read of 0x10, memory answers two cycles after mem_valid
    fixed_wait = 2;
    add(0, 32'h10, 32'h0, 4'h0);
    run_until_done(50, "t1");

    // 2: simultaneous requests straight after reset
    apply_reset();
    fixed_wait = 1;
    g_who.delete(); g_cyc.delete();
    add(0, 32'h100, 32'h0, 4'h0);
    add(1, 32'h200, 32'h0, 4'h0);
    run_until_done(50, "t2");
    chk("t2_grants", 64'(g_who.size()), 64'(2));
    if (g_who.size() >= 2) begin
      chk("t2_first",  64'(g_who[0]), 64'(0));
      chk("t2_second", 64'(g_who[1]), 64'(1));
    end

    // 3: continuous requests from both, zero-wait memory
    fixed_wait = 0;
    g_who.delete(); g_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      add(0, ADDR_W'(32'h40 + 4 * i), $urandom, '0);
      add(1, ADDR_W'(32'h80 + 4 * i), $urandom, '0);
    end
    run_until_done(100, "t3");
    chk("t3_grants", 64'(g_who.size()), 64'(8));
    zeros = 0;
    foreach (g_who[i]) begin
      if (g_who[i] == 0) zeros++;
      if (i > 0) begin
        chk("t3_alternate", 64'(g_who[i] != g_who[i-1]), 64'(1));
        chk("t3_spacing",   64'(g_cyc[i] - g_cyc[i-1]), 64'(3));
      end
    end
    chk("t3_m0_share", 64'(zeros), 64'(4));

    // 4: m1 write, then m0 reads it back
    fixed_wait = -1;
    add(1, 32'h20, 32'h12345678, 4'hF);
    run_until_done(50, "t4w");
    add(0, 32'h20, 32'h0, 4'h0);
    run_until_done(50, "t4r");

    // 5: reset while a transaction waits on memory
    fixed_wait = 3;
    add(0, 32'h44, 32'h0, 4'h0);
    for (int i = 0; i < 10 && !mem_valid; i++) step();
    chk("t5_in_busy", 64'(mem_valid), 64'(1));
    apply_reset();
    fixed_wait = 0;
    g_who.delete(); g_cyc.delete();
    add(0, 32'h100, 32'h0, 4'h0);
    add(1, 32'h200, 32'h0, 4'h0);
    run_until_done(50, "t5");
    chk("t5_grants", 64'(g_who.size()), 64'(2));
    if (g_who.size() >= 1) chk("t5_first", 64'(g_who[0]), 64'(0));

    // 6: stray mem_ready while idle, then zero-wait response
    p_spur = 100;
    repeat (6) step();
    add(1, 32'h30, 32'h0, 4'h0);
    run_until_done(50, "t6");
    p_spur = 0;

    // randomized traffic
    p_spur = 20;
    fixed_wait = -1;
    for (int r = 0; r < 8; r++) begin
      p_req0 = int'($urandom_range(20, 100));
      p_req1 = (r == 3) ? 0 : int'($urandom_range(20, 100));
      for (int i = 0; i < 15; i++) begin
        plan0.push_back(rnd_txn());
        if (r != 3) plan1.push_back(rnd_txn());
      end
      run_until_done(2000, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_mem_arbiter.md
Name: iob_mem_arbiter

Overview:
- Two-requester arbiter sharing one native-interface memory port: the system memory path in front of the AXI DDR bridge.
- Requester 0 is the instruction side; requester 1 is the data side.
- Round-robin arbitration, one outstanding transaction at a time.
- All memory-side request signals and requester responses are registered.

Parameters:
ADDR_W, 32, address width on requester and memory ports
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
m0_valid  input  1  requester 0 request
m0_addr  input  ADDR_W  requester 0 byte address
m0_wdata  input  DATA_W  requester 0 write data
m0_wstrb  input  DATA_W/8  requester 0 byte enables; 0 = read
m0_rdata  output  DATA_W  requester 0 read data
m0_ready  output  1  requester 0 completion pulse
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready  same as m0_*, for requester 1
mem_valid  output  1  memory request
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wstrb  output  DATA_W/8  memory byte enables
mem_rdata  input  DATA_W  memory read data
mem_ready  input  1  memory completion, one-cycle pulse
grant  output  1  index of the last or current granted requester
busy  output  1  high in BUSY and RESP states

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, grant=1 (so requester 0 wins the first tie). All of the following are 0: mem_valid, mem_addr, mem_wdata, mem_wstrb, rdata register, m0_ready, m1_ready, busy.
- Requester rule (native interface): hold valid, addr, wdata and wstrb stable until ready is seen. A requester may re-assert or keep valid high in the cycle after ready for a new transaction.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no valid: stay in IDLE.
- IDLE, exactly one valid: grant that requester.
- IDLE, both valid: grant the requester != grant (the other one from last time).
- On a grant: register the selected addr, wdata and wstrb onto the mem_* outputs, set grant, set mem_valid=1, go to BUSY. mem_valid rises the cycle after the IDLE cycle in which valid was seen.
- BUSY: mem_valid and the mem_* fields are held constant. On mem_ready, capture mem_rdata into the rdata register, clear mem_valid, go to RESP. mem_ready is accepted in the first BUSY cycle (the cycle in which mem_valid first reads 1).
- RESP: the granted requester's ready is 1 for exactly this cycle; the other ready is 0. Requester valids are ignored in this cycle. Next state is IDLE.
- m0_rdata and m1_rdata both drive the rdata register. The value is meaningful only while the corresponding ready is high, and holds until the next capture.
- mem_ready outside BUSY is ignored: no state change, no ready pulse.
- Latency:
  - requester valid at cycle t (IDLE) -> mem_valid at t+1;
  - mem_ready at cycle k ≥ t+1 -> requester ready and rdata at k+1;
  - IDLE again at k+2.
  - Minimum is 3 cycles per transaction.
- Fairness: under continuous requests from both requesters, grants strictly alternate. A lone requester is served back-to-back without penalty.
- A valid that drops while the arbiter is in IDLE is simply not granted (protocol violation only if it drops after being granted; the arbiter does not check this).
- Reset mid-transaction: immediate return to reset values. The in-flight transaction is abandoned with no ready pulse, and grant is restored to 1.
- Writes: wstrb≠0 is passed through unchanged. The rdata register still captures mem_rdata, and the requester ignores it.

Test Plan:
1. m0 read addr 0x10, wstrb 0; memory answers 2 cycles after mem_valid with 0xDEADBEEF -> mem_addr=0x10 and mem_wstrb=0 while mem_valid is high; m0_ready=1 for one cycle with m0_rdata=0xDEADBEEF; m1_ready stays 0.
2. After reset, m0 (addr 0x100) and m1 (addr 0x200) assert valid in the same cycle -> mem_addr sequence 0x100 then 0x200; grant 0 then 1; each ready is a single pulse.
3. Both requesters keep valid high for 4 transactions each, memory ready after 0 wait cycles -> grants 0,1,0,1,…; each transaction takes 3 cycles; neither requester is starved.
4. m1 write addr 0x20, wdata 0x12345678, wstrb 0xF -> mem_wdata=0x12345678 and mem_wstrb=0xF held until mem_ready; m1_ready pulses; m0 untouched.
5. rst asserted while in BUSY (mem_valid=1) -> mem_valid, busy and both readies go to 0 asynchronously; after release, a simultaneous m0/m1 request grants m0 first.
6. mem_ready pulsed while IDLE with no requests -> no state change, no ready pulse. mem_ready in the same cycle mem_valid first rises -> ready pulses on the next cycle.
